sonata_sw_debounce: RTL and testbench



---
 rtl/sonata_sw_pkg.sv | 21 ++
 rtl/sonata_debounce_chan.sv | 50 +++++
 rtl/sonata_sw_debounce.sv | 53 +++++
 tb/tb_sonata_sw_debounce.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/sonata_sw_pkg.sv
// Shared constants for the Sonata board switch conditioning path.
// Switch bit layout: nav joystick in the low bits, user DIP above it.
package sonata_sw_pkg;

    localparam int NavSwWidth = 5;
    localparam int UsrSwWidth = 8;
    localparam int SwWidth    = NavSwWidth + UsrSwWidth;

    localparam int DefaultCntWidth       = 20;
    localparam int DefaultDebounceCycles = 500000;

    localparam int NavUp    = 0;
    localparam int NavDown  = 1;
    localparam int NavLeft  = 2;
    localparam int NavRight = 3;
    localparam int NavPress = 4;
    localparam int UsrBase  = NavSwWidth;

    typedef logic [SwWidth-1:0] sw_vec_t;

endpackage

// File: rtl/sonata_debounce_chan.sv
// One switch bit: input register, 2-flop synchroniser, stability
// counter, accepted level and registered rise/fall pulses.
module sonata_debounce_chan #(
    parameter int CntWidth       = 20,
    parameter int DebounceCycles = 500000,
    parameter bit InvertIn       = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic level,
    output logic rise,
    output logic fall
);

    localparam logic [CntWidth-1:0] Last = CntWidth'(DebounceCycles - 1);

    // Flops keep pin polarity so they reset to the idle pin level;
    // inversion is applied after the synchroniser.
    logic [2:0]          pipe;
    logic                sync;
    logic [CntWidth-1:0] cnt;

    assign sync = pipe[2] ^ InvertIn;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pipe  <= {3{InvertIn}};
            cnt   <= '0;
            level <= 1'b0;
            rise  <= 1'b0;
            fall  <= 1'b0;
        end else begin
            pipe <= {pipe[1:0], raw};
            rise <= 1'b0;
            fall <= 1'b0;
            if (sync == level) begin
                cnt <= '0;
            end else if (cnt == Last) begin
                level <= sync;
                cnt   <= '0;
                rise  <= sync;
                fall  <= ~sync;
            end else begin
                cnt <= cnt + CntWidth'(1);
            end
        end
    end

endmodule

// File: rtl/sonata_sw_debounce.sv
// Board switch conditioning in front of GPI: per-bit debounce channels
// plus sticky change flags and a combined change request.
module sonata_sw_debounce
    import sonata_sw_pkg::*;
#(
    parameter int Width          = SwWidth,
    parameter int CntWidth       = DefaultCntWidth,
    parameter int DebounceCycles = DefaultDebounceCycles,
    parameter bit InvertIn       = 1'b1
) (
    input  logic             clk_sys_i,
    input  logic             rst_sys_i,
    input  logic [Width-1:0] sw_raw_i,
    output logic [Width-1:0] sw_o,
    output logic [Width-1:0] rise_o,
    output logic [Width-1:0] fall_o,
    output logic [Width-1:0] changed_o,
    input  logic [Width-1:0] changed_clr_i,
    output logic             any_changed_o
);

    if (DebounceCycles < 1 ||
        longint'(DebounceCycles) >= (longint'(1) << CntWidth)) begin : g_param_err
        $fatal(1, "DebounceCycles out of range for CntWidth");
    end

    for (genvar i = 0; i < Width; i++) begin : g_chan
        sonata_debounce_chan #(
            .CntWidth       (CntWidth),
            .DebounceCycles (DebounceCycles),
            .InvertIn       (InvertIn)
        ) u_chan (
            .clk   (clk_sys_i),
            .rst   (rst_sys_i),
            .raw   (sw_raw_i[i]),
            .level (sw_o[i]),
            .rise  (rise_o[i]),
            .fall  (fall_o[i])
        );
    end

    // A new edge beats a same-cycle clear so no event is lost.
    always_ff @(posedge clk_sys_i or posedge rst_sys_i) begin
        if (rst_sys_i) begin
            changed_o     <= '0;
            any_changed_o <= 1'b0;
        end else begin
            changed_o     <= (changed_o & ~changed_clr_i) | rise_o | fall_o;
            any_changed_o <= |changed_o;
        end
    end

endmodule

// File: tb/tb_sonata_sw_debounce.sv
// Randomised and directed bench for sonata_sw_debounce against a
// window-based behavioural model of the debounce rules.
module tb_sonata_sw_debounce;

    localparam int W  = 13;
    localparam int DC = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic [W-1:0] raw;
    logic [W-1:0] clr;
    logic [W-1:0] sw;
    logic [W-1:0] rise;
    logic [W-1:0] fall;
    logic [W-1:0] changed;
    logic         any;

    int checks = 0;
    int errors = 0;

    // Model: raw pins seen three edges late, a level flips once the
    // last DC delayed samples all disagree with it.
    logic [W-1:0] m_d   [3];
    logic [W-1:0] m_win [DC];
    logic [W-1:0] m_sw, m_rise, m_fall, m_chg;
    logic         m_any;

    always #5 clk = ~clk;

    sonata_sw_debounce #(
        .Width          (W),
        .CntWidth       (20),
        .DebounceCycles (DC),
        .InvertIn       (1'b1)
    ) dut (
        .clk_sys_i     (clk),
        .rst_sys_i     (rst),
        .sw_raw_i      (raw),
        .sw_o          (sw),
        .rise_o        (rise),
        .fall_o        (fall),
        .changed_o     (changed),
        .changed_clr_i (clr),
        .any_changed_o (any)
    );

    task automatic check_eq(string tag, logic [W-1:0] got, logic [W-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 3; i++) m_d[i] = '1;
        for (int i = 0; i < DC; i++) m_win[i] = '0;
        m_sw   = '0;
        m_rise = '0;
        m_fall = '0;
        m_chg  = '0;
        m_any  = 1'b0;
    endtask

    task automatic model_step();
        logic [W-1:0] eff, all_on, all_off, flip;
        eff    = ~m_d[2];
        m_d[2] = m_d[1];
        m_d[1] = m_d[0];
        m_d[0] = raw;
        for (int i = DC - 1; i > 0; i--) m_win[i] = m_win[i-1];
        m_win[0] = eff;
        all_on  = '1;
        all_off = '1;
        for (int i = 0; i < DC; i++) begin
            all_on  = all_on & m_win[i];
            all_off = all_off & ~m_win[i];
        end
        flip   = (all_on & ~m_sw) | (all_off & m_sw);
        m_any  = |m_chg;
        m_chg  = (m_chg & ~clr) | m_rise | m_fall;
        m_rise = flip & ~m_sw;
        m_fall = flip & m_sw;
        m_sw   = m_sw ^ flip;
    endtask

    task automatic check_all(string tag);
        check_eq({tag, "_sw"}, sw, m_sw);
        check_eq({tag, "_rise"}, rise, m_rise);
        check_eq({tag, "_fall"}, fall, m_fall);
        check_eq({tag, "_chg"}, changed, m_chg);
        check_eq({tag, "_any"}, W'(any), W'(m_any));
    endtask

    task automatic cycle(string tag);
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_all(tag);
    endtask

    task automatic async_reset(string tag);
        #2 rst = 1'b1;
        model_reset();
        #1 check_all({tag, "_now"});
        check_eq({tag, "_sw0"}, sw, '0);
        @(posedge clk);
        @(negedge clk);
        check_all({tag, "_hold"});
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        raw = '1;
        clr = '0;
        model_reset();
        repeat (3) @(negedge clk);
        check_all("reset");
        rst = 1'b0;

        for (int i = 0; i < 50; i++) cycle("idle");
        check_eq("idle_sw", sw, '0);
        check_eq("idle_any", W'(any), '0);

        // bit 0 pressed: level and rise after 2+DC edges from first sample
        raw[0] = 1'b0;
        for (int i = 0; i < 6; i++) begin
            cycle("press0");
            check_eq("press0_early", rise & W'(1), '0);
        end
        cycle("press0");
        check_eq("press0_rise", rise, W'(1));
        check_eq("press0_sw", sw, W'(1));
        cycle("press0");
        check_eq("press0_rise1", rise, '0);
        check_eq("press0_chg", changed, W'(1));
        cycle("press0");
        check_eq("press0_any", W'(any), W'(1));

        // bit 3 bounce shorter than the debounce window
        raw[3] = 1'b0; repeat (3) cycle("bounce");
        raw[3] = 1'b1; cycle("bounce");
        raw[3] = 1'b0; repeat (3) cycle("bounce");
        raw[3] = 1'b1;
        for (int i = 0; i < 12; i++) begin
            cycle("bounce");
            check_eq("bounce_sw3", sw & W'(8), '0);
            check_eq("bounce_edge3", (rise | fall) & W'(8), '0);
        end

        // clear of bit 0
        clr[0] = 1'b1; cycle("clr0");
        clr[0] = 1'b0;
        check_eq("clr0_chg", changed, '0);
        cycle("clr0");
        check_eq("clr0_any", W'(any), '0);

        // clear coinciding with a fall pulse: set wins
        raw[0] = 1'b1;
        repeat (7) cycle("rel0");
        check_eq("rel0_fall", fall, W'(1));
        clr[0] = 1'b1; cycle("setwins");
        clr[0] = 1'b0;
        check_eq("setwins_chg", changed, W'(1));

        // bits 5 and 12 together
        raw[5]  = 1'b0;
        raw[12] = 1'b0;
        repeat (9) cycle("on5_12");
        check_eq("on5_12_sw", sw, W'(13'h1020));
        clr = '1; cycle("clrall");
        clr = '0;
        raw[5]  = 1'b1;
        raw[12] = 1'b1;
        for (int i = 0; i < 6; i++) begin
            cycle("off5_12");
            check_eq("off5_12_early", fall, '0);
        end
        cycle("off5_12");
        check_eq("off5_12_fall", fall, W'(13'h1020));
        check_eq("off5_12_sw", sw, '0);

        // async reset mid-count with bit 7 held on
        raw[7] = 1'b0;
        repeat (4) cycle("cnt7");
        async_reset("rst7");
        for (int i = 0; i < 6; i++) begin
            cycle("after7");
            check_eq("after7_early", rise, '0);
        end
        cycle("after7");
        check_eq("after7_rise", rise, W'(13'h0080));

        // random soak
        for (int n = 0; n < 4000; n++) begin
            raw = raw ^ (W'($urandom) & W'($urandom) &
                         W'($urandom) & W'($urandom));
            clr = ($urandom_range(0, 7) == 0) ? W'($urandom) : '0;
            if ($urandom_range(0, 599) == 0)
                async_reset("rnd_rst");
            else
                cycle("rnd");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
